// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide, 32 iterations.
// Latency: accept at E0, HI/LO written and done pulsed after E33; busy stalls decode in between.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t      r_state, w_next;
    logic [5:0]  r_cnt;
    logic        r_is_div, r_neg_q, r_neg_r, r_dz;
    logic [31:0] r_acc, r_q, r_b;
    logic        r_done, r_div_zero;
    logic [31:0] r_hi, r_lo;

    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag;
    logic [32:0] w_sum, w_rem_sh, w_diff;
    logic [31:0] w_acc_n, w_q_n;
    logic [63:0] w_prod, w_prod_fix;
    logic [31:0] w_quo_fix, w_rem_fix;

    // op[0] set means unsigned: operands are taken raw.
    assign w_a_neg = ~op[0] & src_a[31];
    assign w_b_neg = ~op[0] & src_b[31];
    assign w_a_mag = w_a_neg ? (~src_a + 32'd1) : src_a;
    assign w_b_mag = w_b_neg ? (~src_b + 32'd1) : src_b;

    assign w_sum    = {1'b0, r_acc} + {1'b0, r_b};
    assign w_rem_sh = {r_acc, r_q[31]};
    assign w_diff   = w_rem_sh - {1'b0, r_b};

    always_comb begin
        w_acc_n = r_acc;
        w_q_n   = r_q;
        if (r_is_div) begin
            // A zero divisor never borrows, giving an all-ones quotient and remainder = dividend.
            w_acc_n = w_diff[32] ? w_rem_sh[31:0] : w_diff[31:0];
            w_q_n   = {r_q[30:0], ~w_diff[32]};
        end else if (r_q[0]) begin
            w_acc_n = w_sum[32:1];
            w_q_n   = {w_sum[0], r_q[31:1]};
        end else begin
            w_acc_n = {1'b0, r_acc[31:1]};
            w_q_n   = {r_acc[0], r_q[31:1]};
        end
    end

    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_q ? (~w_prod + 64'd1) : w_prod;
    assign w_quo_fix  = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? (~r_q + 32'd1) : r_q);
    assign w_rem_fix  = r_neg_r ? (~r_acc + 32'd1) : r_acc;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CALC;
            CALC:    if (r_cnt == 6'd31) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 6'd0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_acc      <= 32'd0;
            r_q        <= 32'd0;
            r_b        <= 32'd0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
        end else begin
            r_done     <= (r_state == FIN) && !flush;
            r_div_zero <= (r_state == FIN) && !flush && r_dz;
            if (r_state == IDLE && !flush) begin
                if (hi_we) r_hi <= wdata;
                if (lo_we) r_lo <= wdata;
                if (start) begin
                    r_cnt    <= 6'd0;
                    r_is_div <= op[1];
                    r_neg_q  <= w_a_neg ^ w_b_neg;
                    r_neg_r  <= w_a_neg;
                    r_dz     <= op[1] && (src_b == 32'd0);
                    r_acc    <= 32'd0;
                    r_q      <= op[1] ? w_a_mag : w_b_mag;
                    r_b      <= op[1] ? w_b_mag : w_a_mag;
                end
            end else if (r_state == CALC) begin
                r_cnt <= r_cnt + 6'd1;
                r_acc <= w_acc_n;
                r_q   <= w_q_n;
            end else if (r_state == FIN && !flush) begin
                if (r_is_div) begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end else begin
                    r_hi <= w_prod_fix[63:32];
                    r_lo <= w_prod_fix[31:0];
                end
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected HI/LO, a monitor checks on done.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst, start, hi_we, lo_we, flush;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   done_seen = 0;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .flush(flush),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    exp_t m_e;
    always @(negedge clk) begin
        if (!rst && done) begin
            done_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with hi=0x%08h lo=0x%08h, required no done", hi, lo);
            end else begin
                m_e = sb.pop_front();
                check("result_hi", hi, m_e.hi);
                check("result_lo", lo, m_e.lo);
                check("div_zero", {31'd0, div_zero}, {31'd0, m_e.dz});
            end
        end
    end

    // Called at a negedge; the following posedge is the acceptance edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input exp_t e);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        src_a = $urandom;
        src_b = $urandom;
    endtask

    task automatic wait_done(output int waits, output int nbusy);
        waits = 0;
        nbusy = 0;
        while (!done && waits < 100) begin
            if (busy) nbusy++;
            @(negedge clk);
            waits++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", waits);
        end
    endtask

    task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
        hi_we = h;
        lo_we = l;
        wdata = d;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    initial begin
        int waits, nbusy, seen;
        rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; flush = 1'b0;
        op = 2'd0; src_a = 32'd0; src_b = 32'd0; wdata = 32'd0;
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy_done_dz", {29'd0, busy, done, div_zero}, 32'd0);
        rst = 1'b0;

        // MULTU max x max, accepted at the first edge after reset
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, '{32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        wait_done(waits, nbusy);
        check("multu_done_edge", waits + 1, 32'd34);
        check("multu_busy_cycles", nbusy, 32'd33);
        check("busy_in_done_cycle", {31'd0, busy}, 32'd0);

        // Back-to-back: each start lands in the previous done cycle
        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1, '{32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
        wait_done(waits, nbusy);
        check("mult_done_edge", waits + 1, 32'd34);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
        wait_done(waits, nbusy);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, '{32'h0000_0000, 32'h8000_0000, 1'b0});
        wait_done(waits, nbusy);
        issue(2'b11, 32'd100, 32'd0, 1'b1, '{32'h0000_0064, 32'hFFFF_FFFF, 1'b1});
        wait_done(waits, nbusy);
        issue(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b1, '{32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1});
        wait_done(waits, nbusy);
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1, '{32'h0000_0001, 32'hFFFF_FFFD, 1'b0});
        wait_done(waits, nbusy);
        issue(2'b00, 32'h8000_0000, 32'd2, 1'b1, '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
        wait_done(waits, nbusy);

        // Start pulsed mid-operation must be ignored
        @(negedge clk);
        issue(2'b11, 32'd100, 32'd7, 1'b1, '{32'h0000_0002, 32'h0000_000E, 1'b0});
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b00; src_a = 32'd5; src_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(waits, nbusy);
        check("divu_mid_start_edge", waits + 7, 32'd34);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        repeat (40) @(negedge clk);

        // MTHI/MTLO in idle, both together and singly
        mt_write(1'b1, 1'b1, 32'h0000_A5A5);
        check("mt_both_hi", hi, 32'h0000_A5A5);
        check("mt_both_lo", lo, 32'h0000_A5A5);
        mt_write(1'b0, 1'b1, 32'h0000_0022);
        check("mtlo_lo", lo, 32'h0000_0022);
        check("mtlo_hi_kept", hi, 32'h0000_A5A5);

        // Start with MTHI in the same cycle, then MTHI while busy
        hi_we = 1'b1; wdata = 32'h0000_0077;
        issue(2'b01, 32'd3, 32'd5, 1'b1, '{32'h0000_0000, 32'h0000_000F, 1'b0});
        hi_we = 1'b0;
        check("mthi_with_start", hi, 32'h0000_0077);
        mt_write(1'b1, 1'b0, 32'h0000_0099);
        check("mthi_ignored_busy", hi, 32'h0000_0077);
        wait_done(waits, nbusy);
        @(negedge clk);

        // Flush at cycle 10 of a DIVU
        mt_write(1'b1, 1'b0, 32'h0000_0011);
        seen = done_seen;
        issue(2'b11, 32'd100, 32'd3, 1'b0, '0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_hi_kept", hi, 32'h0000_0011);
        check("flush_lo_kept", lo, 32'h0000_000F);
        repeat (45) @(negedge clk);
        check("flush_no_done", done_seen, seen);

        // Asynchronous reset at cycle 20 of a MULT
        issue(2'b00, 32'd5, 32'd6, 1'b0, '0);
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (45) @(negedge clk);
        check("arst_no_done", done_seen, seen);
        check("arst_hi_stays", hi, 32'd0);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running at 100000, required completion");
        $fatal(1);
    end
endmodule
